// File: rtl/rotary_param_pkg.sv
// Shared types and default constants for the rotary parameter sequencer.
package rotary_param_pkg;

  localparam int unsigned DefNumParams   = 8;
  localparam int unsigned DefValW        = 15;
  localparam int unsigned DefMaxVal      = 16383;
  localparam int unsigned DefDefaultVal  = 8192;
  localparam int unsigned DefCoarseShift = 5;
  localparam int unsigned DefHoldCycles  = 25000000;
  localparam int unsigned AccelShift     = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCalc  = 2'd1,
    StWrite = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EvNone    = 2'd0,
    EvStep    = 2'd1,
    EvSelect  = 2'd2,
    EvDefault = 2'd3
  } ev_type_e;

  typedef struct packed {
    ev_type_e kind;
    logic     left;
    logic     coarse;
    logic     accel;
  } event_t;

endpackage

// File: rtl/press_hold_detect.sv
// Turns the synchronized push level into a press-edge pulse and a single long-hold pulse.
module press_hold_detect #(
  parameter int unsigned HoldCycles = 25000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic press_i,
  output logic select_o,
  output logic default_o
);

  localparam int unsigned CntW = $clog2(HoldCycles + 1);
  localparam logic [CntW-1:0] HoldMax  = CntW'(HoldCycles);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);

  logic            press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter parks at HoldMax so a long hold yields one pulse until release.
  always_comb begin
    cnt_d = cnt_q;
    if (!press_i) begin
      cnt_d = '0;
    end else if (cnt_q != HoldMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign select_o  = press_i & ~press_q;
  assign default_o = press_i & (cnt_q == HoldLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      press_q <= press_i;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/rotary_param_sequencer.sv
// Rotary-encoder driven parameter editor with saturating slots and a write handshake.
// Optional PARAM_ACCEL_EN: steps closer than 2^16 cycles apart get an 8x step size.
module rotary_param_sequencer
  import rotary_param_pkg::*;
#(
  parameter int unsigned NUM_PARAMS   = DefNumParams,
  parameter int unsigned VAL_W        = DefValW,
  parameter int unsigned MAX_VAL      = DefMaxVal,
  parameter int unsigned DEFAULT_VAL  = DefDefaultVal,
  parameter int unsigned COARSE_SHIFT = DefCoarseShift,
  parameter int unsigned HOLD_CYCLES  = DefHoldCycles
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enc_step,
  input  logic                          enc_left,
  input  logic                          enc_press,
  input  logic                          coarse,
  output logic [$clog2(NUM_PARAMS)-1:0] sel_out,
  output logic [VAL_W-1:0]              val_out,
  output logic                          wr_valid,
  output logic [$clog2(NUM_PARAMS)-1:0] wr_addr,
  output logic [VAL_W-1:0]              wr_data,
  input  logic                          wr_ready,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int unsigned SelW  = $clog2(NUM_PARAMS);
  localparam int unsigned CalcW = VAL_W + 1;
  localparam logic [CalcW-1:0] MaxCalc = CalcW'(MAX_VAL);
  localparam logic [VAL_W-1:0] DefVal  = VAL_W'(DEFAULT_VAL);
  localparam logic [SelW-1:0]  LastSel = SelW'(NUM_PARAMS - 1);

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [VAL_W-1:0] slots_q [NUM_PARAMS];
  logic [VAL_W-1:0] slots_d [NUM_PARAMS];
  event_t          cur_q, cur_d, pend_q, pend_d, in_ev;
  logic            pend_valid_q, pend_valid_d;
  logic            wr_valid_q, wr_valid_d;
  logic [SelW-1:0] wr_addr_q, wr_addr_d;
  logic [VAL_W-1:0] wr_data_q, wr_data_d;
  logic            overflow_q, overflow_d;
  logic            sel_pulse, def_pulse, in_valid, multi_drop, drop, accel_hit;
  logic [CalcW-1:0] delta, slot_ext, sum, step_val;
  logic [VAL_W-1:0] new_val;

  press_hold_detect #(
    .HoldCycles(HOLD_CYCLES)
  ) u_press (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .press_i  (enc_press),
    .select_o (sel_pulse),
    .default_o(def_pulse)
  );

`ifdef PARAM_ACCEL_EN
  logic [16:0] gap_q, gap_d;
  logic        seen_q, seen_d;

  // gap_q[16] marks that 2^16 cycles have elapsed since the last step.
  always_comb begin
    gap_d  = gap_q;
    seen_d = seen_q;
    if (enc_step) begin
      gap_d  = '0;
      seen_d = 1'b1;
    end else if (!gap_q[16]) begin
      gap_d = gap_q + 17'd1;
    end
  end

  assign accel_hit = seen_q & ~gap_q[16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      seen_q <= seen_d;
    end
  end
`else
  assign accel_hit = 1'b0;
`endif

  always_comb begin
    in_ev = '0;
    if (def_pulse) begin
      in_ev.kind = EvDefault;
    end else if (sel_pulse) begin
      in_ev.kind = EvSelect;
    end else if (enc_step) begin
      in_ev.kind   = EvStep;
      in_ev.left   = enc_left;
      in_ev.coarse = coarse;
      in_ev.accel  = accel_hit;
    end
  end

  assign in_valid   = def_pulse | sel_pulse | enc_step;
  assign multi_drop = (def_pulse & (sel_pulse | enc_step)) | (sel_pulse & enc_step);

  // Saturating step arithmetic on the selected slot, one bit wider than a slot.
  always_comb begin
    delta = cur_q.coarse ? (CalcW'(1) << COARSE_SHIFT) : CalcW'(1);
    if (cur_q.accel) begin
      delta = delta << AccelShift;
    end
    slot_ext = {1'b0, slots_q[sel_q]};
    sum      = slot_ext + delta;
    if (cur_q.left) begin
      step_val = (delta > slot_ext) ? '0 : (slot_ext - delta);
    end else begin
      step_val = (sum > MaxCalc) ? MaxCalc : sum;
    end
    new_val = (cur_q.kind == EvDefault) ? DefVal : step_val[VAL_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    slots_d      = slots_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    drop         = multi_drop;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          cur_d        = pend_q;
          state_d      = StCalc;
          pend_d       = in_ev;
          pend_valid_d = in_valid;
        end else if (in_valid) begin
          cur_d   = in_ev;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cur_q.kind == EvSelect) begin
          sel_d   = (sel_q == LastSel) ? '0 : (sel_q + SelW'(1));
          state_d = StIdle;
        end else begin
          slots_d[sel_q] = new_val;
          wr_valid_d     = 1'b1;
          wr_addr_d      = sel_q;
          wr_data_d      = new_val;
          state_d        = StWrite;
        end
      end
      StWrite: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && in_valid) begin
      if (pend_valid_q) begin
        drop = 1'b1;
      end else begin
        pend_d       = in_ev;
        pend_valid_d = 1'b1;
      end
    end

    val_d      = slots_d[sel_d];
    overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      val_q        <= DefVal;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        slots_q[i] <= DefVal;
      end
      cur_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      val_q        <= val_d;
      slots_q      <= slots_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sel_out  = sel_q;
  assign val_out  = val_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rotary_param_sequencer.sv
// Directed bench for rotary_param_sequencer with a shortened press-hold time.
module tb_rotary_param_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enc_step = 1'b0;
  logic        enc_left = 1'b0;
  logic        enc_press = 1'b0;
  logic        coarse = 1'b0;
  logic        wr_ready = 1'b1;
  logic        overflow_clr = 1'b0;
  logic [2:0]  sel_out, wr_addr;
  logic [14:0] val_out, wr_data;
  logic        wr_valid, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;

  rotary_param_sequencer #(
    .HOLD_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enc_step    (enc_step),
    .enc_left    (enc_left),
    .enc_press   (enc_press),
    .coarse      (coarse),
    .sel_out     (sel_out),
    .val_out     (val_out),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Counts cycles with wr_valid high; with wr_ready=1 each write is one cycle.
  always @(negedge clk) begin
    if (wr_valid) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_drive(input logic left, input logic c);
    enc_left = left;
    coarse   = c;
    enc_step = 1'b1;
    tick();
    enc_step = 1'b0;
  endtask

  task automatic step_nochk(input logic left, input logic c);
    step_drive(left, c);
    tick();
    tick();
  endtask

  task automatic step_chk(input string tag, input logic left, input logic c,
                          input logic [31:0] addr, input logic [31:0] data);
    step_drive(left, c);
    check({tag, " n+1 valid"}, wr_valid, 0);
    tick();
    check({tag, " n+2 valid"}, wr_valid, 1);
    check({tag, " addr"}, wr_addr, addr);
    check({tag, " data"}, wr_data, data);
    tick();
  endtask

  task automatic press_edge();
    enc_press = 1'b1;
    tick();
    enc_press = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    int   c0;
    logic ok;
    logic [31:0] got_addr, got_data;

    tick();
    tick();
    check("rst sel", sel_out, 0);
    check("rst val", val_out, 8192);
    check("rst wr_valid", wr_valid, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    step_chk("inc1", 1'b0, 1'b0, 0, 8193);
    step_chk("inc2", 1'b0, 1'b0, 0, 8194);
    step_chk("inc3", 1'b0, 1'b0, 0, 8195);
    check("val after inc", val_out, 8195);

    c0 = wr_cnt;
    for (int i = 1; i <= 8; i++) begin
      press_edge();
      check("sel cycle", sel_out, i % 8);
    end
    check("no write on select", wr_cnt, c0);

    // Slot 0: 8195 + 255*32 + 25 = 16380
    repeat (255) step_nochk(1'b0, 1'b1);
    repeat (25) step_nochk(1'b0, 1'b0);
    check("slot0 16380", val_out, 16380);
    step_chk("sat hi", 1'b0, 1'b1, 0, 16383);
    step_chk("sat hi again", 1'b0, 1'b0, 0, 16383);

    press_edge();
    check("sel 1", sel_out, 1);
    check("slot1 val", val_out, 8192);
    // Slot 1: 8192 - 255*32 - 29 = 3
    repeat (255) step_nochk(1'b1, 1'b1);
    repeat (29) step_nochk(1'b1, 1'b0);
    check("slot1 3", val_out, 3);
    step_chk("sat lo", 1'b1, 1'b1, 1, 0);

    // Backpressure: first extra step buffered, second dropped.
    wr_ready = 1'b0;
    enc_left = 1'b0;
    coarse   = 1'b0;
    enc_step = 1'b1;
    tick();
    enc_step = 1'b0;
    tick();
    check("bp valid", wr_valid, 1);
    check("bp data", wr_data, 1);
    check("bp addr", wr_addr, 1);
    enc_step = 1'b1;
    tick();
    enc_step = 1'b0;
    tick();
    check("bp buffered no ovf", overflow, 0);
    enc_step = 1'b1;
    tick();
    enc_step = 1'b0;
    check("bp drop ovf", overflow, 1);
    repeat (5) tick();
    check("bp hold valid", wr_valid, 1);
    check("bp hold data", wr_data, 1);
    wr_ready = 1'b1;
    tick();
    check("bp accepted", wr_valid, 0);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wr_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp pending served", ok, 1);
    check("bp pending data", wr_data, 2);
    check("bp pending addr", wr_addr, 1);
    tick();
    c0 = wr_cnt;
    repeat (10) tick();
    check("bp no third write", wr_cnt, c0);
    check("bp val", val_out, 2);
    check("bp ovf sticky", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf cleared", overflow, 0);

    press_edge();
    check("sel 2", sel_out, 2);
    step_chk("edit slot2", 1'b0, 1'b0, 2, 8193);
    repeat (7) press_edge();
    check("sel back to 1", sel_out, 1);

    // Hold: the press edge selects slot 2, the hold then recentres it.
    c0 = wr_cnt;
    got_addr = '1;
    got_data = '1;
    enc_press = 1'b1;
    repeat (250) begin
      tick();
      if (wr_valid) begin
        got_addr = wr_addr;
        got_data = wr_data;
      end
    end
    enc_press = 1'b0;
    repeat (3) tick();
    check("hold one write", wr_cnt - c0, 1);
    check("hold addr", got_addr, 2);
    check("hold data", got_data, 8192);
    check("hold sel", sel_out, 2);
    check("hold val", val_out, 8192);

    wr_ready = 1'b0;
    step_drive(1'b0, 1'b0);
    tick();
    check("pre-rst valid", wr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst mid-write valid", wr_valid, 0);
    check("rst mid-write sel", sel_out, 0);
    check("rst mid-write data", wr_data, 0);
    check("rst mid-write val", val_out, 8192);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    c0 = wr_cnt;
    repeat (6) tick();
    check("no retry", wr_cnt, c0);
    for (int i = 0; i < 8; i++) begin
      check("post-rst sel", sel_out, i);
      check("post-rst slot", val_out, 8192);
      press_edge();
    end
    check("post-rst wrap", sel_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
